ttl_reg_bank: RTL and testbench

TTL_REG_BANK -- requirements
Module: ttl_reg_bank

---
 rtl/ttl_pkg.sv | 19 +
 rtl/ttl_reg_cell.sv | 55 +++++
 rtl/ttl_reg_bank.sv | 78 +++++++
 tb/tb_ttl_reg_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ttl_pkg.sv
// ============================================================================
// Module  : ttl_pkg
// Purpose : Shared operation encodings for the TTL-style register bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ttl_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD       = 2'b00,
        MODE_SHIFT_UP   = 2'b01,
        MODE_SHIFT_DOWN = 2'b10,
        MODE_CLEAR      = 2'b11
    } mode_e;

endpackage

`default_nettype wire

// File: rtl/ttl_reg_cell.sv
// ============================================================================
// Module  : ttl_reg_cell
// Purpose : One channel register with async clear, next-value mux and a
//           registered change flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ttl_reg_cell
    import ttl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_bar,
    input  logic [1:0]       mode,
    input  logic             enable_bar,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] shift_value,
    output logic [WIDTH-1:0] q,
    output logic             changed
);

    logic [WIDTH-1:0] r_q;
    logic             r_changed;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_q;
        case (mode_e'(mode))
            MODE_LOAD:       if (!enable_bar) w_next = load_value;
            MODE_SHIFT_UP:   w_next = shift_value;
            MODE_SHIFT_DOWN: w_next = shift_value;
            MODE_CLEAR:      if (!enable_bar) w_next = '0;
            default:         w_next = r_q;
        endcase
    end

    // Flag compares against the held value, so rewriting identical data stays quiet.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_q       <= '0;
            r_changed <= 1'b0;
        end else begin
            r_q       <= w_next;
            r_changed <= (w_next != r_q);
        end
    end

    assign q       = r_q;
    assign changed = r_changed;

endmodule

`default_nettype wire

// File: rtl/ttl_reg_bank.sv
// ============================================================================
// Module  : ttl_reg_bank
// Purpose : Multi-channel register bank with parallel load, word-wide shift
//           up/down, per-channel clear and per-channel change flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ttl_reg_bank
    import ttl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                      Clk,
    input  logic                      Reset_bar,
    input  logic [CHANNELS-1:0]       Enable_bar,
    input  logic [1:0]                Mode,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [WIDTH-1:0]          Serial_in,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [WIDTH-1:0]          Serial_out_hi,
    output logic [WIDTH-1:0]          Serial_out_lo,
    output logic [CHANNELS-1:0]       Changed
);

    // Output delays are a simulation-model notion; this synthesizable view is zero-delay.
    if (WIDTH < 1 || CHANNELS < 1 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_params
    end

    logic [CHANNELS*WIDTH-1:0] w_q;
    logic                      w_shift_down;

    assign w_shift_down = (Mode == MODE_SHIFT_DOWN);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [WIDTH-1:0] w_from_below;
        logic [WIDTH-1:0] w_from_above;
        logic [WIDTH-1:0] w_shift;

        // Neighbours come from the registered bus, so a shift never ripples.
        if (i == 0) begin : g_bottom
            assign w_from_below = Serial_in;
        end else begin : g_below
            assign w_from_below = w_q[(i-1)*WIDTH +: WIDTH];
        end

        if (i == CHANNELS - 1) begin : g_top
            assign w_from_above = Serial_in;
        end else begin : g_above
            assign w_from_above = w_q[(i+1)*WIDTH +: WIDTH];
        end

        assign w_shift = w_shift_down ? w_from_above : w_from_below;

        ttl_reg_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk        (Clk),
            .reset_bar  (Reset_bar),
            .mode       (Mode),
            .enable_bar (Enable_bar[i]),
            .load_value (D[i*WIDTH +: WIDTH]),
            .shift_value(w_shift),
            .q          (w_q[i*WIDTH +: WIDTH]),
            .changed    (Changed[i])
        );
    end

    assign Q             = w_q;
    assign Serial_out_hi = w_q[(CHANNELS-1)*WIDTH +: WIDTH];
    assign Serial_out_lo = w_q[0 +: WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_ttl_reg_bank.sv
// ============================================================================
// Module  : tb_ttl_reg_bank
// Purpose : Randomised, model-checked bench for ttl_reg_bank (4x8 and 1x1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ttl_reg_bank;

    logic        Clk = 1'b0;
    logic        Reset_bar = 1'b1;
    always #5 Clk = ~Clk;

    // 4 channels x 8 bits
    logic [3:0]  a_en = 4'hF;
    logic [1:0]  a_mode = 2'b00;
    logic [31:0] a_d = '0;
    logic [7:0]  a_sin = '0;
    logic [31:0] a_q;
    logic [7:0]  a_hi, a_lo;
    logic [3:0]  a_chg;

    // 1 channel x 1 bit
    logic        b_en = 1'b1;
    logic [1:0]  b_mode = 2'b00;
    logic        b_d = 1'b0;
    logic        b_sin = 1'b0;
    logic        b_q, b_hi, b_lo, b_chg;

    ttl_reg_bank #(.WIDTH(8), .CHANNELS(4), .DELAY_RISE(0), .DELAY_FALL(0)) u_dut_a (
        .Clk(Clk), .Reset_bar(Reset_bar), .Enable_bar(a_en), .Mode(a_mode),
        .D(a_d), .Serial_in(a_sin), .Q(a_q), .Serial_out_hi(a_hi),
        .Serial_out_lo(a_lo), .Changed(a_chg)
    );

    ttl_reg_bank #(.WIDTH(1), .CHANNELS(1), .DELAY_RISE(0), .DELAY_FALL(0)) u_dut_b (
        .Clk(Clk), .Reset_bar(Reset_bar), .Enable_bar(b_en), .Mode(b_mode),
        .D(b_d), .Serial_in(b_sin), .Q(b_q), .Serial_out_hi(b_hi),
        .Serial_out_lo(b_lo), .Changed(b_chg)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: channel words and change flags after the most recent edge.
    logic [7:0] m [4] = '{default: 8'h00};
    logic [3:0] mchg = 4'h0;
    logic       mb = 1'b0;
    logic       mbchg = 1'b0;

    function automatic logic [31:0] packm();
        return {m[3], m[2], m[1], m[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        chk("q",       a_q,               packm());
        chk("changed", {28'h0, a_chg},    {28'h0, mchg});
        chk("hi",      {24'h0, a_hi},     {24'h0, m[3]});
        chk("lo",      {24'h0, a_lo},     {24'h0, m[0]});
        chk("b_q",     {31'h0, b_q},      {31'h0, mb});
        chk("b_chg",   {31'h0, b_chg},    {31'h0, mbchg});
        chk("b_hi_lo", {31'h0, b_hi},     {31'h0, b_lo});
    end

    task automatic drive(input logic [1:0] mo, input logic [3:0] en, input logic [31:0] dd,
                         input logic [7:0] si, input logic [1:0] bmo, input logic ben,
                         input logic bd, input logic bsi);
        logic [7:0] nx [4];
        logic       nb;
        @(negedge Clk);
        a_mode = mo; a_en = en; a_d = dd; a_sin = si;
        b_mode = bmo; b_en = ben; b_d = bd; b_sin = bsi;
        for (int i = 0; i < 4; i++) nx[i] = m[i];
        nb = mb;
        case (mo)
            2'b00: for (int i = 0; i < 4; i++) if (!en[i]) nx[i] = dd[i*8 +: 8];
            2'b01: begin
                nx[0] = si;
                for (int i = 1; i < 4; i++) nx[i] = m[i-1];
            end
            2'b10: begin
                nx[3] = si;
                for (int i = 0; i < 3; i++) nx[i] = m[i+1];
            end
            default: for (int i = 0; i < 4; i++) if (!en[i]) nx[i] = 8'h00;
        endcase
        case (bmo)
            2'b00:   if (!ben) nb = bd;
            2'b11:   if (!ben) nb = 1'b0;
            default: nb = bsi;
        endcase
        @(posedge Clk);
        #1;
        if (Reset_bar) begin
            for (int i = 0; i < 4; i++) begin
                mchg[i] = (nx[i] != m[i]);
                m[i]    = nx[i];
            end
            mbchg = (nb != mb);
            mb    = nb;
        end
    endtask

    task automatic astep(input logic [1:0] mo, input logic [3:0] en, input logic [31:0] dd,
                         input logic [7:0] si);
        drive(mo, en, dd, si, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic rand_step();
        drive(2'($urandom), 4'($urandom), $urandom, 8'($urandom),
              2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m[i] = 8'h00;
        mchg  = 4'h0;
        mb    = 1'b0;
        mbchg = 1'b0;
    endtask

    initial begin
        #1 Reset_bar = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        chk("reset_q",   a_q,            32'h0);
        chk("reset_chg", {28'h0, a_chg}, 32'h0);
        @(negedge Clk);
        Reset_bar = 1'b1;

        astep(2'b00, 4'b1010, 32'h44332211, 8'h00); #1;
        chk("load_q",   a_q,            32'h00330011);
        chk("load_chg", {28'h0, a_chg}, 32'h5);

        astep(2'b00, 4'b0000, 32'h44332211, 8'h00); #1;
        chk("load_all_q",   a_q,            32'h44332211);
        chk("load_all_chg", {28'h0, a_chg}, 32'hA);

        astep(2'b00, 4'b0000, 32'h44332211, 8'h00); #1;
        chk("same_q",   a_q,            32'h44332211);
        chk("same_chg", {28'h0, a_chg}, 32'h0);

        astep(2'b01, 4'b0000, 32'h0, 8'hAA); #1;
        chk("shup1_q", a_q, 32'h332211AA);
        astep(2'b01, 4'b1111, 32'h0, 8'hBB); #1;
        chk("shup2_q",  a_q,            32'h2211AABB);
        chk("shup2_hi", {24'h0, a_hi},  32'h22);

        astep(2'b00, 4'b0000, 32'h44332211, 8'h00);
        astep(2'b10, 4'b1111, 32'h0, 8'h55); #1;
        chk("shdn_q",  a_q,           32'h55443322);
        chk("shdn_lo", {24'h0, a_lo}, 32'h22);
        astep(2'b11, 4'b0111, 32'h0, 8'h00); #1;
        chk("clr_q",   a_q,            32'h00443322);
        chk("clr_chg", {28'h0, a_chg}, 32'h8);

        repeat (400) rand_step();

        // Asynchronous reset between edges, with a live change flag pending.
        astep(2'b00, 4'b0000, packm() ^ 32'h01010101, 8'h00);
        #1;
        Reset_bar = 1'b0;
        model_reset();
        #1;
        chk("async_q",   a_q,            32'h0);
        chk("async_chg", {28'h0, a_chg}, 32'h0);
        repeat (3) rand_step();
        #2;
        Reset_bar = 1'b1;
        astep(2'b00, 4'b1111, $urandom, 8'($urandom)); #1;
        chk("release_q",   a_q,            32'h0);
        chk("release_chg", {28'h0, a_chg}, 32'h0);

        // Single 1-bit channel: both shift directions load Serial_in.
        drive(2'($urandom), 4'($urandom), $urandom, 8'($urandom), 2'b01, 1'b1, 1'b0, 1'b1); #1;
        chk("b_up_1", {31'h0, b_q}, 32'h1);
        drive(2'($urandom), 4'($urandom), $urandom, 8'($urandom), 2'b10, 1'b1, 1'b1, 1'b0); #1;
        chk("b_dn_0", {31'h0, b_q}, 32'h0);
        drive(2'($urandom), 4'($urandom), $urandom, 8'($urandom), 2'b10, 1'b0, 1'b0, 1'b1); #1;
        chk("b_dn_1", {31'h0, b_hi}, 32'h1);
        drive(2'($urandom), 4'($urandom), $urandom, 8'($urandom), 2'b01, 1'b0, 1'b1, 1'b0); #1;
        chk("b_up_0", {31'h0, b_lo}, 32'h0);

        repeat (200) rand_step();

        @(negedge Clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
